// File: rtl/de_morgan_pkg.sv
// Shared types and reference helpers for the De Morgan NOR sweep tester.
package de_morgan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Widest operand the reference helper handles; also keeps the vector count inside 32 bits.
  localparam int MAXW = 15;

  function automatic int unsigned num_vectors(input int unsigned w);
    return 32'd1 << (2 * w);
  endfunction

  function automatic logic [MAXW-1:0] nor_ref(input logic [MAXW-1:0] a,
                                               input logic [MAXW-1:0] b);
    return ~a & ~b;
  endfunction

endpackage

// File: rtl/de_morgan_tester.sv
// Walks every {a,b} operand pair into a NOR gate, waits SETTLE cycles,
// and scores the returned c against ~a & ~b.
module de_morgan_tester
  import de_morgan_pkg::*;
#(
  parameter int W      = 1,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   c_in,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_cnt,
  output logic [2*W-1:0] first_fail,
  output logic           fail_seen
);

  localparam int VW    = 2 * W;
  localparam int EW    = 2 * W + 1;
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SLAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int unsigned NVEC = num_vectors(W);
  localparam logic [VW-1:0] VLAST = VW'(NVEC - 1);

  state_e        state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [EW-1:0] err_q, err_d;
  logic [VW-1:0] ff_q, ff_d;
  logic          fs_q, fs_d;

  logic [W-1:0]  expected;
  logic          mism;

  // Reference is taken from the registered operands actually presented to the gate.
  assign expected = W'(nor_ref(MAXW'(a_q), MAXW'(b_q)));
  assign mism     = (c_in != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fs_d    = fs_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          fs_d    = 1'b0;
        end
      end
      DRIVE: begin
        a_d     = vec_q[VW-1:W];
        b_d     = vec_q[W-1:0];
        cnt_d   = '0;
        state_d = (SETTLE > 0) ? WAIT : CHECK;
      end
      WAIT: begin
        if (cnt_q == CW'(SLAST)) state_d = CHECK;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      CHECK: begin
        if (mism) begin
          err_d = err_q + EW'(1);
          if (!fs_q) begin
            ff_d = {a_q, b_q};
            fs_d = 1'b1;
          end
        end
        // The last vector's CHECK ends the sweep, so vec never wraps.
        if (vec_q == VLAST) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + VW'(1);
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign busy       = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == '0);
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
  assign fail_seen  = fs_q;

endmodule

// File: tb/tb_de_morgan_tester.sv
// Bench: three tester configurations, each looped through a table-driven gate model.
module tb_de_morgan_tester;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   sel;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] tbl [16];

  always #5 clk = ~clk;

  // Instance 0: W=1 SETTLE=1
  logic [0:0] a0, b0, c0;
  logic       busy0, done0, pass0, fs0;
  logic [2:0] e0;
  logic [1:0] f0;
  assign c0 = tbl[{2'b00, a0, b0}][0:0];
  de_morgan_tester #(.W(1), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(start && sel == 0), .c_in(c0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(e0), .first_fail(f0), .fail_seen(fs0));

  // Instance 1: W=1 SETTLE=0
  logic [0:0] a1, b1, c1;
  logic       busy1, done1, pass1, fs1;
  logic [2:0] e1;
  logic [1:0] f1;
  assign c1 = tbl[{2'b00, a1, b1}][0:0];
  de_morgan_tester #(.W(1), .SETTLE(0)) u1 (
    .clk(clk), .rst(rst), .start(start && sel == 1), .c_in(c1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(e1), .first_fail(f1), .fail_seen(fs1));

  // Instance 2: W=2 SETTLE=2
  logic [1:0] a2, b2, c2;
  logic       busy2, done2, pass2, fs2;
  logic [4:0] e2;
  logic [3:0] f2;
  assign c2 = tbl[{a2, b2}][1:0];
  de_morgan_tester #(.W(2), .SETTLE(2)) u2 (
    .clk(clk), .rst(rst), .start(start && sel == 2), .c_in(c2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(e2), .first_fail(f2), .fail_seen(fs2));

  logic [1:0] va, vb;
  logic       vbusy, vdone, vpass, vfs;
  logic [4:0] verr;
  logic [3:0] vff;

  always_comb begin
    va = '0; vb = '0; vbusy = 1'b0; vdone = 1'b0; vpass = 1'b0; vfs = 1'b0;
    verr = '0; vff = '0;
    case (sel)
      0: begin
        va = {1'b0, a0}; vb = {1'b0, b0}; vbusy = busy0; vdone = done0;
        vpass = pass0; vfs = fs0; verr = {2'b00, e0}; vff = {2'b00, f0};
      end
      1: begin
        va = {1'b0, a1}; vb = {1'b0, b1}; vbusy = busy1; vdone = done1;
        vpass = pass1; vfs = fs1; verr = {2'b00, e1}; vff = {2'b00, f1};
      end
      default: begin
        va = a2; vb = b2; vbusy = busy2; vdone = done2;
        vpass = pass2; vfs = fs2; verr = e2; vff = f2;
      end
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (sel=%0d t=%0t)", nm, act, exp, sel, $time);
    end
  endtask

  // Gate kinds: 0 NOR, 1 stuck-at-0, 2 NAND, 3 OR, 4 NOR with bit1 stuck-at-1, 5 NOR with random flips
  task automatic fill(input int w, input int kind);
    int m, a, b, nor_v;
    m = (1 << w) - 1;
    for (int v = 0; v < 16; v++) begin
      a = (v >> w) & m;
      b = v & m;
      nor_v = ~(a | b) & m;
      case (kind)
        0: tbl[v] = 4'(nor_v);
        1: tbl[v] = 4'd0;
        2: tbl[v] = 4'(~(a & b) & m);
        3: tbl[v] = 4'((a | b) & m);
        4: tbl[v] = 4'(nor_v | 2);
        default: tbl[v] = 4'((nor_v ^ (($urandom_range(0, 3) == 0) ? $urandom : 0)) & m);
      endcase
    end
  endtask

  // Expected score of a whole sweep, straight from the truth table.
  task automatic model(input int w, output int err, output int ff, output int fs);
    int m, a, b;
    m = (1 << w) - 1;
    err = 0; ff = 0; fs = 0;
    for (int v = 0; v < (1 << (2 * w)); v++) begin
      a = (v >> w) & m;
      b = v & m;
      if ((int'(tbl[v]) & m) != (~(a | b) & m)) begin
        err++;
        if (fs == 0) begin ff = v; fs = 1; end
      end
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, 32'(va), 0);
    chk({nm, "_b"}, 32'(vb), 0);
    chk({nm, "_busy"}, 32'(vbusy), 0);
    chk({nm, "_done"}, 32'(vdone), 0);
    chk({nm, "_pass"}, 32'(vpass), 0);
    chk({nm, "_err"}, 32'(verr), 0);
    chk({nm, "_ff"}, 32'(vff), 0);
    chk({nm, "_fs"}, 32'(vfs), 0);
  endtask

  task automatic run(input int s, input int w, input int st, input int extra_at,
                     input int rst_at, input int lit_err, input int lit_ff);
    int me, mff, mfs, n, p, len, m, vi;
    bit aborted;
    sel = s;
    model(w, me, mff, mfs);
    if (lit_err >= 0) chk("model_err", me, lit_err);
    if (lit_ff >= 0)  chk("model_ff", mff, lit_ff);
    n = 1 << (2 * w);
    p = st + 2;
    len = n * p;
    m = (1 << w) - 1;
    aborted = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_t0", 32'(vbusy), 1);
    chk("done_t0", 32'(vdone), 0);
    for (int t = 1; t <= len; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      vi = (t - 1) / p;
      chk("busy", 32'(vbusy), (t < len) ? 1 : 0);
      chk("done", 32'(vdone), (t >= len) ? 1 : 0);
      chk("a_out", 32'(va), (vi >> w) & m);
      chk("b_out", 32'(vb), vi & m);
      if (t == extra_at) start = 1'b1;
      if (t == rst_at) begin
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        #1 rst = 1'b0;
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      chk("err_cnt", 32'(verr), me);
      chk("first_fail", 32'(vff), mff);
      chk("fail_seen", 32'(vfs), mfs);
      chk("pass", 32'(vpass), (me == 0) ? 1 : 0);
      if (lit_err >= 0) chk("err_lit", 32'(verr), lit_err);
      if (lit_ff >= 0)  chk("ff_lit", 32'(vff), lit_ff);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      chk("done_hold", 32'(vdone), 1);
      chk("err_hold", 32'(verr), me);
      chk("a_hold", 32'(va), m);
      chk("b_hold", 32'(vb), m);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; sel = 0;
    fill(1, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk_zero("reset");
    end
    rst = 1'b0;

    fill(1, 0); run(0, 1, 1, -1, -1, 0, 0);
    fill(1, 1); run(0, 1, 1, -1, -1, 1, 0);
    fill(1, 2); run(0, 1, 1, -1, -1, 2, 1);
    fill(1, 3); run(1, 1, 0, -1, -1, 4, 0);
    fill(1, 0); run(0, 1, 1, 4, -1, 0, 0);
    fill(1, 0); run(0, 1, 1, -1, 5, -1, -1);
    run(0, 1, 1, -1, -1, 0, 0);
    fill(2, 4); run(2, 2, 2, -1, -1, 12, 2);

    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 2);
      if (k == 2) begin fill(2, 5); run(2, 2, 2, -1, -1, -1, -1); end
      else begin fill(1, 5); run(k, 1, (k == 0) ? 1 : 0, -1, -1, -1, -1); end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
